// File: rtl/entrada_senha_pkg.sv
// Shared types and constants for the entrada_senha code-entry controller.
package entrada_senha_pkg;

  localparam int SYM_W = 2;

  typedef enum logic [1:0] {
    ARMED    = 2'd0,
    DEFUSED  = 2'd1,
    EXPLODED = 2'd2
  } estado_t;

  localparam logic [SYM_W-1:0] SYM_A = 2'b00;
  localparam logic [SYM_W-1:0] SYM_B = 2'b01;
  localparam logic [SYM_W-1:0] SYM_C = 2'b10;
  localparam logic [SYM_W-1:0] SYM_D = 2'b11;

endpackage

// File: rtl/debouncer_tecla.sv
// Synchronizes and debounces the active-low enter key; emits a one-cycle
// press strobe on each accepted 1->0 transition of the debounced level.
module debouncer_tecla #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n_i,
  output logic press_o
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_q, sync2_q;
  logic             level_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        // Level flips after DEBOUNCE_CYCLES consecutive differing samples;
        // only the released->pressed direction is an event.
        level_q <= sync2_q;
        cnt_q   <= '0;
        press_q <= level_q;
      end else begin
        cnt_q <= cnt_q + CNT_ONE;
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/entrada_senha.sv
// Code-entry controller: checks debounced key presses against the defusal
// sequence. Strike limiting is enabled by ENTRADA_SENHA_STRIKE_LIMIT_EN.
module entrada_senha
  import entrada_senha_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SEQ_LEN         = 4,
  parameter int MAX_ERRORS      = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     key_n,
  input  logic [SYM_W-1:0]         sym,
  input  logic [SYM_W*SEQ_LEN-1:0] code,
  input  logic                     time_up,
  output logic                     defused,
  output logic                     exploded,
  output logic [2:0]               pos,
  output logic [1:0]               errors,
  output logic [SYM_W*SEQ_LEN-1:0] entered,
  output logic                     error_pulse,
  output estado_t                  state_dbg
);

  localparam int         ENT_W     = SYM_W * SEQ_LEN;
  localparam logic [2:0] POS_LAST  = 3'(SEQ_LEN - 1);
  localparam logic [2:0] POS_DONE  = 3'(SEQ_LEN);
  localparam logic [1:0] ERR_LIMIT = 2'(MAX_ERRORS);

  estado_t          state_q;
  logic [2:0]       pos_q;
  logic [ENT_W-1:0] entered_q;
  logic             error_pulse_q;
  logic             press;
  logic [SYM_W-1:0] code_sym;
  logic             strike;

  debouncer_tecla #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk     (clk),
    .rst     (rst),
    .key_n_i (key_n),
    .press_o (press)
  );

  assign code_sym = code[SYM_W*int'(pos_q) +: SYM_W];

`ifdef ENTRADA_SENHA_STRIKE_LIMIT_EN
  logic [1:0] errors_q, errors_d;
  assign errors_d = errors_q + 2'd1;
  assign strike   = (errors_d == ERR_LIMIT);
  assign errors   = errors_q;
`else
  logic unused_err_limit;
  assign unused_err_limit = ^ERR_LIMIT;
  assign strike           = 1'b0;
  assign errors           = 2'd0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ARMED;
      pos_q         <= 3'd0;
      entered_q     <= '0;
      error_pulse_q <= 1'b0;
`ifdef ENTRADA_SENHA_STRIKE_LIMIT_EN
      errors_q      <= 2'd0;
`endif
    end else begin
      error_pulse_q <= 1'b0;
      // time_up wins over a same-cycle press; terminal states hold everything.
      if (state_q == ARMED) begin
        if (time_up) begin
          state_q <= EXPLODED;
        end else if (press) begin
          entered_q <= {sym, entered_q[ENT_W-1:SYM_W]};
          if (sym == code_sym) begin
            if (pos_q == POS_LAST) begin
              pos_q   <= POS_DONE;
              state_q <= DEFUSED;
            end else begin
              pos_q <= pos_q + 3'd1;
            end
          end else begin
            pos_q         <= 3'd0;
            error_pulse_q <= 1'b1;
`ifdef ENTRADA_SENHA_STRIKE_LIMIT_EN
            errors_q      <= errors_d;
`endif
            if (strike) state_q <= EXPLODED;
          end
        end
      end
    end
  end

  assign defused     = (state_q == DEFUSED);
  assign exploded    = (state_q == EXPLODED);
  assign pos         = pos_q;
  assign entered     = entered_q;
  assign error_pulse = error_pulse_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_entrada_senha.sv
// Directed bench for entrada_senha (DEBOUNCE_CYCLES=4, SEQ_LEN=4, code A,B,D,C);
// expectations follow ENTRADA_SENHA_STRIKE_LIMIT_EN when it is defined.
module tb_entrada_senha;
  import entrada_senha_pkg::*;

`ifdef ENTRADA_SENHA_STRIKE_LIMIT_EN
  localparam bit STRIKE = 1'b1;
`else
  localparam bit STRIKE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_n = 1'b1;
  logic [1:0] sym = 2'b00;
  logic [7:0] code = 8'b10_11_01_00;
  logic       time_up = 1'b0;
  logic       defused, exploded, error_pulse;
  logic [2:0] pos;
  logic [1:0] errors;
  logic [7:0] entered;
  estado_t    state_dbg;

  int n_vec = 0;
  int n_miss = 0;
  int pulse_cycles = 0;
  int lat;
  int base;

  always #5 clk = ~clk;

  entrada_senha #(.DEBOUNCE_CYCLES(4), .SEQ_LEN(4), .MAX_ERRORS(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_n       (key_n),
    .sym         (sym),
    .code        (code),
    .time_up     (time_up),
    .defused     (defused),
    .exploded    (exploded),
    .pos         (pos),
    .errors      (errors),
    .entered     (entered),
    .error_pulse (error_pulse),
    .state_dbg   (state_dbg)
  );

  always @(posedge clk) if (error_pulse === 1'b1) pulse_cycles++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; key_n = 1'b1; time_up = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic press_key(input logic [1:0] s);
    @(negedge clk);
    sym = s; key_n = 1'b0;
    repeat (12) @(negedge clk);
    key_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic chk_outputs(input string tag, input logic d, input logic x,
                             input logic [2:0] p, input logic [1:0] e, input logic [7:0] h);
    chk({tag, "_defused"},  32'(defused),  32'(d));
    chk({tag, "_exploded"}, 32'(exploded), 32'(x));
    chk({tag, "_pos"},      32'(pos),      32'(p));
    chk({tag, "_errors"},   32'(errors),   32'(e));
    chk({tag, "_entered"},  32'(entered),  32'(h));
  endtask

  initial begin
    // Reset values
    do_reset();
    chk_outputs("rst", 1'b0, 1'b0, 3'd0, 2'd0, 8'h00);
    chk("rst_pulse", 32'(error_pulse), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'(ARMED));

    // Clean sequence A,B,D,C; first press also measures key latency
    @(negedge clk);
    sym = SYM_A; key_n = 1'b0; lat = 0;
    while (pos == 3'd0 && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    chk("key_latency", 32'(lat), 32'd7);
    repeat (12) @(negedge clk);
    key_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("seq_pos1", 32'(pos), 32'd1);
    press_key(SYM_B); chk("seq_pos2", 32'(pos), 32'd2);
    press_key(SYM_D); chk("seq_pos3", 32'(pos), 32'd3);
    chk("seq_not_yet", 32'(defused), 32'd0);
    press_key(SYM_C);
    chk_outputs("seq_done", 1'b1, 1'b0, 3'd4, 2'd0, 8'b10_11_01_00);
    chk("seq_state", 32'(state_dbg), 32'(DEFUSED));
    press_key(SYM_A);
    chk_outputs("defused_hold", 1'b1, 1'b0, 3'd4, 2'd0, 8'b10_11_01_00);

    // A then wrong C, then full sequence
    do_reset();
    base = pulse_cycles;
    press_key(SYM_A);
    press_key(SYM_C);
    chk("wrong_pulse", 32'(pulse_cycles - base), 32'd1);
    chk_outputs("wrong", 1'b0, 1'b0, 3'd0, STRIKE ? 2'd1 : 2'd0, 8'b10_00_00_00);
    press_key(SYM_A); press_key(SYM_B); press_key(SYM_D); press_key(SYM_C);
    chk_outputs("retry", 1'b1, 1'b0, 3'd4, STRIKE ? 2'd1 : 2'd0, 8'b10_11_01_00);
    chk("retry_pulse", 32'(pulse_cycles - base), 32'd1);

    // Three wrong symbols
    do_reset();
    base = pulse_cycles;
    press_key(SYM_C); press_key(SYM_C);
    chk("strike2_exploded", 32'(exploded), 32'd0);
    press_key(SYM_C);
    chk("strike_pulses", 32'(pulse_cycles - base), 32'd3);
    chk_outputs("strike3", 1'b0, STRIKE, 3'd0, STRIKE ? 2'd3 : 2'd0, 8'b10_10_10_00);
    press_key(SYM_A);
    chk_outputs("strike_after", 1'b0, STRIKE, STRIKE ? 3'd0 : 3'd1,
                STRIKE ? 2'd3 : 2'd0, STRIKE ? 8'b10_10_10_00 : 8'b00_10_10_10);

    // Bouncing key: toggles every 2 cycles, then held low
    do_reset();
    base = pulse_cycles;
    sym = SYM_A;
    for (int i = 0; i < 10; i++) begin
      key_n = ~key_n;
      repeat (2) @(negedge clk);
    end
    chk("bounce_none", 32'(pos), 32'd0);
    key_n = 1'b0;
    repeat (10) @(negedge clk);
    key_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("bounce_once", 32'(pos), 32'd1);
    chk("bounce_entered", 32'(entered), 32'h00);
    chk("bounce_pulse", 32'(pulse_cycles - base), 32'd0);

    // time_up coincident with the final correct press
    do_reset();
    press_key(SYM_A); press_key(SYM_B); press_key(SYM_D);
    @(negedge clk);
    sym = SYM_C; key_n = 1'b0;
    repeat (6) @(negedge clk);
    time_up = 1'b1;
    @(negedge clk);
    time_up = 1'b0;
    chk_outputs("timeup", 1'b0, 1'b1, 3'd3, 2'd0, 8'b11_01_00_00);
    chk("timeup_state", 32'(state_dbg), 32'(EXPLODED));
    repeat (12) @(negedge clk);
    key_n = 1'b1;
    repeat (12) @(negedge clk);
    chk_outputs("timeup_hold", 1'b0, 1'b1, 3'd3, 2'd0, 8'b11_01_00_00);

    // Reset after two correct symbols, then accept from scratch
    do_reset();
    press_key(SYM_A); press_key(SYM_B);
    chk("pre_rst_pos", 32'(pos), 32'd2);
    do_reset();
    chk_outputs("mid_rst", 1'b0, 1'b0, 3'd0, 2'd0, 8'h00);
    press_key(SYM_A); press_key(SYM_B); press_key(SYM_D); press_key(SYM_C);
    chk_outputs("after_rst", 1'b1, 1'b0, 3'd4, 2'd0, 8'b10_11_01_00);

    // Reset while key is mid-debounce and still held afterwards
    do_reset();
    @(negedge clk);
    sym = SYM_A; key_n = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("held_rst_wait", 32'(pos), 32'd0);
    repeat (10) @(negedge clk);
    chk("held_rst_once", 32'(pos), 32'd1);
    key_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("held_rst_final", 32'(pos), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
